// File: rtl/fetch_align_queue_pkg.sv
// Shared types and constants for the fetch/align queue: FSM states, NOP encoding,
// default parameters and the compressed-parcel test.
package fetch_align_queue_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_RESP = 2'd1,
    DROP      = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0033;
  localparam int          DEFAULT_DEPTH    = 8;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_compressed(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_queue_parcel_ring.sv
// Circular buffer of 16-bit parcels: pushes/pops 0..2 parcels per cycle and
// exposes the two head parcels combinationally.
module parcel_ring
  import fetch_align_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [1:0]               push_cnt,
  input  logic [31:0]              push_data,
  input  logic [1:0]               pop_cnt,
  output logic [15:0]              head0,
  output logic [15:0]              head1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_cnt != 2'd0) mem[wr_ptr] <= push_data[15:0];
      if (push_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= push_data[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_cnt);
      wr_ptr <= wr_ptr + AW'(push_cnt);
      count  <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

endmodule

// File: rtl/fetch_align_queue.sv
// Instruction fetch front end: issues one word fetch at a time, queues parcels and
// presents aligned 16/32-bit instructions with their PC; handles redirects.
module fetch_align_queue
  import fetch_align_queue_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fetch_req,
  output logic [31:0]            fetch_addr,
  input  logic                   fetch_valid,
  input  logic [31:0]            fetch_data,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc,
  output logic                   out_compressed,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  logic          started;
  logic          skip_lower;
  logic [15:0]   head0;
  logic [15:0]   head1;
  logic [CW-1:0] free_slots;
  logic          accept_resp;
  logic          fire;
  logic [1:0]    push_cnt;
  logic [1:0]    pop_cnt;
  logic [31:0]   push_data;

  // started keeps fetch_req low during reset and for the first cycle after release.
  assign free_slots = CW'(DEPTH) - count;
  assign fetch_req  = started && (state == RUN) && !flush && (free_slots >= CW'(2));

  assign out_compressed = is_compressed(head0);
  assign out_valid      = ((count != '0) && out_compressed) || (count >= CW'(2));
  assign out_inst       = out_compressed ? {16'h0000, head0} : {head1, head0};

  assign accept_resp = (state == WAIT_RESP) && fetch_valid && !flush;
  assign push_cnt    = accept_resp ? (skip_lower ? 2'd1 : 2'd2) : 2'd0;
  assign push_data   = skip_lower ? {16'h0000, fetch_data[31:16]} : fetch_data;
  assign fire        = out_valid && out_ready && !flush;
  assign pop_cnt     = fire ? (out_compressed ? 2'd1 : 2'd2) : 2'd0;

  parcel_ring #(.DEPTH(DEPTH)) ring (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .head0     (head0),
    .head1     (head1),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      started    <= 1'b0;
      skip_lower <= RESET_PC[1];
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      out_pc     <= RESET_PC;
    end else begin
      started <= 1'b1;
      if (flush) begin
        out_pc     <= flush_pc;
        fetch_addr <= {flush_pc[31:2], 2'b00};
        skip_lower <= flush_pc[1];
        // An in-flight request must still be absorbed before fetching again.
        case (state)
          WAIT_RESP, DROP: state <= fetch_valid ? RUN : DROP;
          default:         state <= RUN;
        endcase
      end else begin
        if (fire) out_pc <= out_pc + (out_compressed ? 32'd2 : 32'd4);
        case (state)
          RUN: if (fetch_req) state <= WAIT_RESP;
          WAIT_RESP: begin
            if (fetch_valid) begin
              state      <= RUN;
              fetch_addr <= fetch_addr + 32'd4;
              skip_lower <= 1'b0;
            end
          end
          DROP:    if (fetch_valid) state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Randomized bench: a word memory answers fetches, and a PC-walking model of the
// instruction stream checks every instruction the queue hands to decode.
module tb_fetch_align_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_valid;
  logic [31:0]   fetch_data;
  logic          flush;
  logic [31:0]   flush_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic          out_compressed;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fetch_align_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_valid    (fetch_valid),
    .fetch_data     (fetch_data),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_compressed (out_compressed),
    .count          (count)
  );

  logic [31:0] mem [256];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Bench-side state: memory responder, expected PC stream, stimulus knobs.
  logic [31:0] exp_pc = 32'h0;
  logic        pending = 1'b0;
  logic        stale = 1'b0;
  logic [31:0] req_addr = 32'h0;
  int          delay = 0;
  int          min_delay = 0;
  int          max_delay = 0;
  int          ready_mode = 0;
  int          flush_rate = 0;
  logic        dir_flush = 1'b0;
  logic [31:0] dir_flush_pc = 32'h0;
  int          n_accepted = 0;
  logic        last_req = 1'b0;
  logic        last_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic model_comp(input logic [31:0] pc);
    logic [15:0] h;
    h = half(pc);
    return h[1:0] != 2'b11;
  endfunction

  function automatic logic [31:0] model_inst(input logic [31:0] pc);
    if (model_comp(pc)) return {16'h0000, half(pc)};
    return {half(pc + 32'd2), half(pc)};
  endfunction

  // One clock cycle: drive inputs at the falling edge, sample 1 time unit later.
  task automatic step();
    logic [31:0] fpc;
    @(negedge clk);
    fetch_valid = 1'b0;
    fetch_data  = $urandom;
    if (pending) begin
      if (delay == 0) begin
        fetch_valid = 1'b1;
        fetch_data  = stale ? 32'hFFFF_FFFF : mem[req_addr[9:2]];
      end else begin
        delay--;
      end
    end
    fpc = {22'h0, 9'($urandom), 1'b0};
    if (dir_flush) fpc = dir_flush_pc;
    flush     = dir_flush || ($urandom_range(99) < flush_rate);
    flush_pc  = fpc;
    dir_flush = 1'b0;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(1));
    endcase
    #1;
    if (out_valid && out_ready && !flush) begin
      check("out_pc", out_pc, exp_pc);
      check("out_inst", out_inst, model_inst(exp_pc));
      check("out_compressed", 32'(out_compressed), 32'(model_comp(exp_pc)));
      exp_pc = exp_pc + (model_comp(exp_pc) ? 32'd2 : 32'd4);
      n_accepted++;
    end
    if (flush) exp_pc = flush_pc;
    last_valid = fetch_valid;
    last_req   = fetch_req;
    if (fetch_valid) begin
      pending = 1'b0;
      stale   = 1'b0;
    end
    if (fetch_req) begin
      check("one_outstanding", 32'(pending), 32'd0);
      check("req_space", 32'(int'(count) <= DEPTH - 2), 32'd1);
      pending  = 1'b1;
      req_addr = fetch_addr;
      delay    = $urandom_range(max_delay, min_delay);
    end
    check("count_bound", 32'(int'(count) <= DEPTH), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_req) break;
    end
    check(tag, 32'(last_req), 32'd1);
  endtask

  initial begin
    int acc0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0]  = 32'h0000_0013;
    mem[1]  = 32'h00A0_0093;
    mem[2]  = 32'h0085_4505;
    mem[3]  = 32'h0093_0001;
    mem[4]  = 32'h0000_00A0;
    mem[64] = 32'h4505_0093;

    rst = 1'b1; fetch_valid = 1'b0; fetch_data = '0; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fetch_req", 32'(fetch_req), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_fetch_addr", fetch_addr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // First response into an empty queue, then stall until full.
    ready_mode = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_valid) break;
    end
    check("first_resp_seen", 32'(last_valid), 32'd1);
    step();
    check("latency_out_valid", 32'(out_valid), 32'd1);
    repeat (30) step();
    check("stall_count_full", 32'(count), 32'(DEPTH));
    check("stall_no_req", 32'(fetch_req), 32'd0);

    ready_mode = 1;
    repeat (40) step();
    check("drain_progress", 32'(n_accepted >= 6), 32'd1);

    // Redirect to an odd-parcel target while a response is still outstanding.
    min_delay = 3; max_delay = 3;
    wait_req("wait_req_flush");
    dir_flush = 1'b1; dir_flush_pc = 32'h0000_0102;
    step();
    step();
    check("flush_fetch_addr", fetch_addr, 32'h0000_0100);
    acc0 = n_accepted;
    repeat (20) step();
    check("post_flush_progress", 32'(n_accepted > acc0), 32'd1);

    // Reset with a request in flight; its late response must be ignored.
    wait_req("wait_req_reset");
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; fetch_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_pc", out_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    stale = 1'b1; pending = 1'b1; delay = 0; exp_pc = 32'h0;
    min_delay = 0; max_delay = 3;
    acc0 = n_accepted;
    repeat (30) step();
    check("post_reset_progress", 32'(n_accepted > acc0), 32'd1);

    // Random phase: random backpressure, latency and redirects.
    ready_mode = 2; flush_rate = 3;
    repeat (2000) step();
    flush_rate = 0; ready_mode = 1;
    acc0 = n_accepted;
    repeat (40) step();
    check("final_progress", 32'(n_accepted > acc0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_align_queue.md
FETCH_ALIGN_QUEUE -- requirements
Module: fetch_align_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue capacity in 16-bit parcels (power of two, >= 4).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, meaning fetch/issue PC after reset.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- fetch_req  out  1  request one instruction word at fetch_addr.
- fetch_addr  out  32  word-aligned fetch address.
- fetch_valid  in  1  response for the single outstanding request.
- fetch_data  in  32  response word, little-endian parcels.
- flush  in  1  redirect (branch/jal/jalr taken).
- flush_pc  in  32  redirect target, bit0 = 0.
- out_valid  out  1  complete instruction at head.
- out_ready  in  1  decode stage accepts; low = stall.
- out_inst  out  32  aligned instruction.
- out_pc  out  32  PC of out_inst.
- out_compressed  out  1  out_inst is 16-bit.
- count  out  $clog2(DEPTH)+1  parcels held.

Function
REQ-005 SHALL store parcels in a circular buffer with wrapping read/write pointers and an occupancy counter 0..DEPTH.
REQ-006 SHALL implement FSM states RUN, WAIT_RESP, DROP; at most one request outstanding.
REQ-007 SHALL assert fetch_req combinationally when state == RUN, flush == 0, and DEPTH - count >= 2; the asserted cycle moves state to WAIT_RESP.
REQ-008 In WAIT_RESP, fetch_valid SHALL push both parcels (low first), add 4 to fetch_addr, and return to RUN.
REQ-009 The first response after a flush to a target with flush_pc[1] = 1 SHALL push only the upper parcel.
REQ-010 Head parcel p0 SHALL be compressed iff p0[1:0] != 2'b11.
REQ-011 out_valid SHALL be 1 iff count >= 1 and p0 is compressed, or count >= 2.
REQ-012 out_inst SHALL be {16'h0, p0} when compressed, else {p1, p0}.
REQ-013 When out_valid && out_ready, the queue SHALL pop 1 parcel (compressed) or 2, and out_pc SHALL advance by 2 or 4 at that edge.
REQ-014 Push and pop in the same cycle SHALL both take effect; count changes by their net difference.
REQ-015 flush SHALL have priority over push and pop, and at the next edge SHALL:
- empty the queue;
- set out_pc = flush_pc;
- set fetch_addr = {flush_pc[31:2], 2'b00}.
REQ-016 flush in WAIT_RESP without fetch_valid SHALL go to DROP; in DROP, fetch_valid SHALL be discarded and the FSM returns to RUN.
REQ-017 flush coincident with fetch_valid SHALL discard the data and go to RUN.
REQ-018 Latency SHALL be: response edge to out_valid high = 1 cycle when queue was empty.
REQ-019 out_inst, out_pc, out_compressed SHALL be don't-care when out_valid = 0; the downstream stage substitutes NOP 32'h00000033.

Reset
REQ-020 While rst = 0, the block SHALL hold: count = 0, pointers = 0, state = RUN, fetch_addr = RESET_PC, out_pc = RESET_PC, out_valid = 0, fetch_req = 0.
REQ-021 Reset mid-request SHALL abandon the outstanding request; the first fetch_valid after reset release without a new request SHALL be ignored.

Structure
REQ-022 A shared package SHALL hold the FSM state enum, the NOP constant 32'h00000033, and the DEPTH/RESET_PC defaults.
REQ-023 Parcel storage SHALL be a sub-module parcel_ring (push 0/1/2, pop 0/1/2, clear, count); FSM, PC and alignment logic stay in fetch_align_queue.

Verification
REQ-024 Scenario: reset, RESET_PC = 0, words 0x00000013 then 0x00A00093 -> out_inst 0x00000013 @ pc 0, then 0x00A00093 @ pc 4, out_compressed = 0.
REQ-025 Scenario: word 0x00854505 -> 0x00004505 compressed @ pc 0, then 0x00000085 compressed @ pc 2.
REQ-026 Scenario: 32-bit instruction spanning words (c.nop 0x0001 then 0x00A00093 split across words 0x00930001, 0x000000A0) -> out_valid for it only after the second word, out_inst 0x00A00093 @ pc 2.
REQ-027 Scenario: out_ready = 0 with DEPTH = 8 -> fetch_req stops at count = 8, no overflow; releasing out_ready drains in order.
REQ-028 Scenario: flush_pc = 0x102 while WAIT_RESP -> stale response dropped, next fetch_addr 0x100, first out_pc 0x102 from the upper parcel.
